// File: rtl/jk_ctrl_pkg.sv
// Shared types and helpers for the JK flop-bank command sequencer.
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StResp
    } jk_state_e;

    // Value a healthy flop must hold after one cycle of the given op.
    function automatic logic jk_expected(input jk_op_e op, input logic pre_q);
        logic res;
        unique case (op)
            JK_HOLD:   res = pre_q;
            JK_RESET:  res = 1'b0;
            JK_SET:    res = 1'b1;
            JK_TOGGLE: res = ~pre_q;
            default:   res = pre_q;
        endcase
        return res;
    endfunction

    // {j, k} pair that performs the given op on one flop.
    function automatic logic [1:0] jk_drive(input jk_op_e op);
        logic [1:0] res;
        unique case (op)
            JK_HOLD:   res = 2'b00;
            JK_RESET:  res = 2'b01;
            JK_SET:    res = 2'b10;
            JK_TOGGLE: res = 2'b11;
            default:   res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command/response handshake bundle between a requester and jk_bank_ctrl.
interface jk_bank_ctrl_if #(
    parameter int unsigned IDX_W = 3
);
    import jk_ctrl_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    jk_op_e           cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_q;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_q, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, rsp_ready,
        output cmd_ready, rsp_valid, rsp_q, rsp_err
    );

endinterface

// File: rtl/jk_ff.sv
// Single JK flip-flop used to build the external bank.
module jk_ff (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // Standard JK behaviour with a synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of NUM_FF JK flops: drives one flop for one cycle,
// reads it back and returns a response.
// Optional read-back check against the expected value: define JK_READBACK_CHECK_EN.
module jk_bank_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FF = 8,
    parameter int unsigned IDX_W  = $clog2(NUM_FF)
) (
    input  logic              clk,
    input  logic              reset,
    jk_bank_ctrl_if.slave     bus,
    output logic [NUM_FF-1:0] j_o,
    output logic [NUM_FF-1:0] k_o,
    input  logic [NUM_FF-1:0] q_i,
    output logic              busy
);

    jk_state_e         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              idx_ok_q;
    logic [NUM_FF-1:0] j_q;
    logic [NUM_FF-1:0] k_q;
    logic              rsp_valid_q;
    logic              rsp_q_q;
    logic              rsp_err_q;
    logic              busy_q;
`ifdef JK_READBACK_CHECK_EN
    jk_op_e            op_q;
    logic              pre_q;
`endif

    logic              cmd_idx_ok;
    logic [1:0]        cmd_jk;

    // Decode the incoming command: index range and the j/k pair to apply.
    always_comb begin
        cmd_idx_ok = 32'(bus.cmd_idx) < NUM_FF;
        cmd_jk     = jk_drive(bus.cmd_op);
    end

    // Sequencer FSM; every output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            idx_ok_q    <= 1'b0;
            j_q         <= '0;
            k_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q_q     <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef JK_READBACK_CHECK_EN
            op_q        <= JK_HOLD;
            pre_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // cmd_ready is high whenever we sit here out of reset.
                    if (bus.cmd_valid) begin
                        state_q  <= StDrive;
                        busy_q   <= 1'b1;
                        idx_q    <= bus.cmd_idx;
                        idx_ok_q <= cmd_idx_ok;
                        j_q      <= '0;
                        k_q      <= '0;
                        if (cmd_idx_ok) begin
                            j_q[bus.cmd_idx] <= cmd_jk[1];
                            k_q[bus.cmd_idx] <= cmd_jk[0];
                        end
`ifdef JK_READBACK_CHECK_EN
                        op_q  <= bus.cmd_op;
                        pre_q <= cmd_idx_ok ? q_i[bus.cmd_idx] : 1'b0;
`endif
                    end
                end
                StDrive: begin
                    // The bank captures j/k at the edge closing this cycle.
                    j_q     <= '0;
                    k_q     <= '0;
                    state_q <= StSample;
                end
                StSample: begin
                    state_q     <= StResp;
                    rsp_valid_q <= 1'b1;
                    if (!idx_ok_q) begin
                        rsp_q_q   <= 1'b0;
                        rsp_err_q <= 1'b1;
                    end else begin
                        rsp_q_q   <= q_i[idx_q];
`ifdef JK_READBACK_CHECK_EN
                        rsp_err_q <= q_i[idx_q] != jk_expected(op_q, pre_q);
`else
                        rsp_err_q <= 1'b0;
`endif
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Ready is suppressed while reset is held so nothing is accepted in that cycle.
    assign bus.cmd_ready = (state_q == StIdle) && !reset;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_q     = rsp_q_q;
    assign bus.rsp_err   = rsp_err_q;
    assign j_o           = j_q;
    assign k_o           = k_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Self-checking bench for jk_bank_ctrl: an 8-flop instance and a 6-flop instance
// (bad-index and stuck-bit cases), each driving a bank of jk_ff flops.
module tb_jk_bank_ctrl;
    import jk_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic bank_rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jk_bank_ctrl_if #(.IDX_W(3)) a_if ();
    jk_bank_ctrl_if #(.IDX_W(3)) b_if ();

    logic [7:0] a_j, a_k, a_q;
    logic [5:0] b_j, b_k, b_q_raw, b_q;
    logic       a_busy, b_busy;
    logic [5:0] stuck;

    assign b_q = b_q_raw & ~stuck;

    jk_bank_ctrl #(.NUM_FF(8)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if),
        .j_o   (a_j),
        .k_o   (a_k),
        .q_i   (a_q),
        .busy  (a_busy)
    );

    jk_bank_ctrl #(.NUM_FF(6)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if),
        .j_o   (b_j),
        .k_o   (b_k),
        .q_i   (b_q),
        .busy  (b_busy)
    );

    for (genvar g = 0; g < 8; g++) begin : g_bank_a
        jk_ff u_ff (.clk(clk), .reset(bank_rst), .j(a_j[g]), .k(a_k[g]), .q(a_q[g]));
    end
    for (genvar g = 0; g < 6; g++) begin : g_bank_b
        jk_ff u_ff (.clk(clk), .reset(bank_rst), .j(b_j[g]), .k(b_k[g]), .q(b_q_raw[g]));
    end

    // Shared requester drive, steered to one DUT by sel.
    logic       sel;
    logic       drv_valid;
    jk_op_e     drv_op;
    logic [2:0] drv_idx;
    logic       drv_rready;

    assign a_if.cmd_valid = drv_valid & ~sel;
    assign b_if.cmd_valid = drv_valid & sel;
    assign a_if.cmd_op    = drv_op;
    assign b_if.cmd_op    = drv_op;
    assign a_if.cmd_idx   = drv_idx;
    assign b_if.cmd_idx   = drv_idx;
    assign a_if.rsp_ready = drv_rready & ~sel;
    assign b_if.rsp_ready = drv_rready & sel;

    wire       obs_ready  = sel ? b_if.cmd_ready : a_if.cmd_ready;
    wire       obs_rvalid = sel ? b_if.rsp_valid : a_if.rsp_valid;
    wire       obs_rq     = sel ? b_if.rsp_q     : a_if.rsp_q;
    wire       obs_rerr   = sel ? b_if.rsp_err   : a_if.rsp_err;
    wire       obs_busy   = sel ? b_busy         : a_busy;
    wire [7:0] obs_j      = sel ? {2'b00, b_j}   : a_j;
    wire [7:0] obs_k      = sel ? {2'b00, b_k}   : a_k;

    // Reference state of each bank: true flop contents.
    logic [7:0] model_a;
    logic [5:0] model_b;

    int n_checks = 0;
    int n_fails  = 0;
    int last_rsp_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it through every cycle to the return to idle.
    task automatic do_cmd(input bit s, input jk_op_e op, input logic [2:0] idx, input int hold);
        int         n;
        int         nff;
        bit         ok;
        logic [7:0] mdl, stk, jx, kx;
        logic [1:0] d;
        logic       pre_v, nxt, vis, exp_q, exp_err;

        nff = s ? 6 : 8;
        ok  = int'(idx) < nff;
        mdl = s ? {2'b00, model_b} : model_a;
        stk = s ? {2'b00, stuck} : 8'h00;
        pre_v = mdl[idx] & ~stk[idx];
        nxt   = jk_expected(op, mdl[idx]);
        vis   = nxt & ~stk[idx];
        exp_q = ok ? vis : 1'b0;
`ifdef JK_READBACK_CHECK_EN
        exp_err = !ok || (vis != jk_expected(op, pre_v));
`else
        exp_err = !ok;
`endif
        d  = jk_drive(op);
        jx = (ok && d[1]) ? (8'd1 << idx) : 8'd0;
        kx = (ok && d[0]) ? (8'd1 << idx) : 8'd0;

        sel = s; drv_op = op; drv_idx = idx; drv_valid = 1'b1; drv_rready = 1'b0;
        #1;
        n = 0;
        while (obs_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_in_time", 32'(n < 20), 1);

        @(negedge clk);  // DRIVE
        drv_valid = 1'b0;
        check("drive_j", 32'(obs_j), 32'(jx));
        check("drive_k", 32'(obs_k), 32'(kx));
        check("drive_busy", 32'(obs_busy), 1);
        check("drive_ready", 32'(obs_ready), 0);
        if (ok) begin
            if (s) model_b[idx] = nxt;
            else   model_a[idx] = nxt;
        end

        @(negedge clk);  // SAMPLE
        check("sample_jk", 32'({obs_j, obs_k}), 0);
        check("sample_rvalid", 32'(obs_rvalid), 0);
        drv_rready = (hold == 0);

        @(negedge clk);  // RESP
        last_rsp_cyc = cyc;
        check("rsp_valid", 32'(obs_rvalid), 1);
        check("rsp_q", 32'(obs_rq), 32'(exp_q));
        check("rsp_err", 32'(obs_rerr), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            drv_valid = 1'b1;  // stray command must be ignored outside idle
            @(negedge clk);
            check("hold_rvalid", 32'(obs_rvalid), 1);
            check("hold_rq", 32'(obs_rq), 32'(exp_q));
            check("hold_ready", 32'(obs_ready), 0);
            check("hold_jk", 32'({obs_j, obs_k}), 0);
        end
        drv_valid = 1'b0; drv_rready = 1'b1;
        @(negedge clk);  // back in IDLE
        drv_rready = 1'b0;
        check("idle_rvalid", 32'(obs_rvalid), 0);
        check("idle_busy", 32'(obs_busy), 0);
        check("idle_ready", 32'(obs_ready), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int     t1;
        bit     s;
        jk_op_e op;

        sel = 1'b0; drv_valid = 1'b0; drv_op = JK_HOLD; drv_idx = 3'd0; drv_rready = 1'b0;
        stuck = 6'h00; reset = 1'b1; bank_rst = 1'b1;
        model_a = 8'h00; model_b = 6'h00;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(obs_ready), 0);
        check("rst_rvalid", 32'(obs_rvalid), 0);
        check("rst_busy", 32'(obs_busy), 0);
        check("rst_jk", 32'({obs_j, obs_k}), 0);
        check("rst_rq", 32'(obs_rq), 0);
        check("rst_rerr", 32'(obs_rerr), 0);
        reset = 1'b0; bank_rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(obs_ready), 1);
        @(negedge clk);

        // Directed sequence on the 8-flop controller.
        do_cmd(1'b0, JK_SET, 3'd3, 0);
        do_cmd(1'b0, JK_TOGGLE, 3'd3, 0);
        t1 = last_rsp_cyc;
        do_cmd(1'b0, JK_TOGGLE, 3'd3, 0);
        check("toggle_spacing", 32'(last_rsp_cyc - t1), 4);
        do_cmd(1'b0, JK_RESET, 3'd0, 0);
        do_cmd(1'b0, JK_HOLD, 3'd0, 0);
        do_cmd(1'b0, JK_SET, 3'd5, 5);

        // 6-flop controller: out-of-range index, then a bit stuck at 0.
        do_cmd(1'b1, JK_SET, 3'd7, 0);
        stuck = 6'b000100;
        do_cmd(1'b1, JK_SET, 3'd2, 0);
        stuck = 6'h00;

        // Reset while the command is in SAMPLE: no response may follow.
        sel = 1'b0; drv_op = JK_TOGGLE; drv_idx = 3'd1; drv_valid = 1'b1;
        #1;
        check("mid_rst_accept", 32'(obs_ready), 1);
        @(negedge clk);
        drv_valid = 1'b0;
        model_a[1] = ~model_a[1];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_low", 32'(obs_ready), 0);
        check("mid_rst_rvalid", 32'(obs_rvalid), 0);
        check("mid_rst_busy", 32'(obs_busy), 0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(obs_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(obs_rvalid), 0);
        end

        // Randomised commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            s  = 1'($urandom_range(0, 1));
            op = jk_op_e'($urandom_range(0, 3));
            do_cmd(s, op, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
